rf_wr_arb: RTL and testbench

RF_WR_ARB -- requirements
Module: rf_wr_arb

---
 rtl/rf_wr_arb_pkg.sv | 20 ++
 rtl/rf_wr_arb_if.sv | 32 +++
 rtl/rf_wr_arb_rr_arb2.sv | 39 +++
 rtl/rf_wr_arb.sv | 90 +++++++++
 tb/tb_rf_wr_arb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wr_arb_pkg.sv
// rtl/rf_wr_arb_pkg.sv - shared register-file widths and helpers for the write arbiter
package rf_wr_arb_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_SEL_W    = 3;
    localparam int RF_NUM_REGS = 8;

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } pref_e;

    function automatic logic [RF_NUM_REGS-1:0] sel_onehot(input logic [RF_SEL_W-1:0] sel);
        logic [RF_NUM_REGS-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rf_wr_arb_if.sv
// rtl/rf_wr_arb_if.sv - requester, stall and register-file write port bundle
interface rf_wr_arb_if
    import rf_wr_arb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int SEL_W  = RF_SEL_W
);
    logic                   a_valid;
    logic [SEL_W-1:0]       a_regsel;
    logic [DATA_W-1:0]      a_data;
    logic                   a_ready;
    logic                   b_valid;
    logic [SEL_W-1:0]       b_regsel;
    logic [DATA_W-1:0]      b_data;
    logic                   b_ready;
    logic                   hold;
    logic [SEL_W-1:0]       writeregsel;
    logic [DATA_W-1:0]      writedata;
    logic                   write;
    logic [RF_NUM_REGS-1:0] pending;
    logic                   err;

    modport master (
        output a_valid, a_regsel, a_data, b_valid, b_regsel, b_data, hold,
        input  a_ready, b_ready, writeregsel, writedata, write, pending, err
    );

    modport slave (
        input  a_valid, a_regsel, a_data, b_valid, b_regsel, b_data, hold,
        output a_ready, b_ready, writeregsel, writedata, write, pending, err
    );
endinterface

// File: rtl/rf_wr_arb_rr_arb2.sv
// rtl/rf_wr_arb_rr_arb2.sv - two-way round-robin arbiter with grant enable
module rr_arb2
    import rf_wr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);
    pref_e ptr;
    pref_e ptr_next;

    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        if (en) begin
            if (req == 2'b11) begin
                grant = (ptr == PREF_A) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
        // Prefer whoever lost (or was absent) once a grant is given.
        if (grant[0]) begin
            ptr_next = PREF_B;
        end else if (grant[1]) begin
            ptr_next = PREF_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PREF_A;
        end else begin
            ptr <= ptr_next;
        end
    end
endmodule

// File: rtl/rf_wr_arb.sv
// rtl/rf_wr_arb.sv - arbitrates two register-file write requesters into one staged write port
module rf_wr_arb
    import rf_wr_arb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int SEL_W  = RF_SEL_W
) (
    input  logic        clk,
    input  logic        rst,
    rf_wr_arb_if.slave  bus
);
    logic              stg_valid;
    logic [SEL_W-1:0]  stg_sel;
    logic [DATA_W-1:0] stg_data;
    logic              drain;
    logic              slot_free;
    logic [1:0]        grant;

    logic              a_stall_q;
    logic              b_stall_q;
    logic [SEL_W-1:0]  a_sel_q;
    logic [SEL_W-1:0]  b_sel_q;
    logic [DATA_W-1:0] a_data_q;
    logic [DATA_W-1:0] b_data_q;
    logic              a_viol;
    logic              b_viol;

    // Reset gates the outputs so a staged write never escapes during reset.
    assign drain     = stg_valid & ~bus.hold & ~rst;
    assign slot_free = ~stg_valid | drain;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({bus.b_valid, bus.a_valid}),
        .en    (slot_free & ~rst),
        .grant (grant)
    );

    assign bus.a_ready     = grant[0];
    assign bus.b_ready     = grant[1];
    assign bus.write       = drain;
    assign bus.writeregsel = stg_sel;
    assign bus.writedata   = stg_data;
    assign bus.pending     = (stg_valid & ~rst) ? sel_onehot(stg_sel) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_sel   <= '0;
            stg_data  <= '0;
        end else if (grant[0]) begin
            stg_valid <= 1'b1;
            stg_sel   <= bus.a_regsel;
            stg_data  <= bus.a_data;
        end else if (grant[1]) begin
            stg_valid <= 1'b1;
            stg_sel   <= bus.b_regsel;
            stg_data  <= bus.b_data;
        end else if (drain) begin
            stg_valid <= 1'b0;
        end
    end

    // A stalled request must stay valid and unchanged until it is granted.
    assign a_viol = a_stall_q & (~bus.a_valid | (bus.a_regsel != a_sel_q) | (bus.a_data != a_data_q));
    assign b_viol = b_stall_q & (~bus.b_valid | (bus.b_regsel != b_sel_q) | (bus.b_data != b_data_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_stall_q <= 1'b0;
            b_stall_q <= 1'b0;
            a_sel_q   <= '0;
            b_sel_q   <= '0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            bus.err   <= 1'b0;
        end else begin
            a_stall_q <= bus.a_valid & ~grant[0];
            b_stall_q <= bus.b_valid & ~grant[1];
            a_sel_q   <= bus.a_regsel;
            b_sel_q   <= bus.b_regsel;
            a_data_q  <= bus.a_data;
            b_data_q  <= bus.b_data;
            if (a_viol | b_viol) begin
                bus.err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rf_wr_arb.sv
// tb/tb_rf_wr_arb.sv - directed scoreboard bench for the register-file write arbiter
module tb_rf_wr_arb;
    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    wr_t  exp_q[$];

    rf_wr_arb_if #(.DATA_W(16), .SEL_W(3)) bus ();

    rf_wr_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] sel, input logic [15:0] data);
        wr_t w;
        w.sel  = sel;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.hold     = 1'b0;
        bus.a_valid  = 1'b1;
        bus.b_valid  = 1'b1;
        @(posedge clk);
        mid();
        chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'h00);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        rst = 1'b0;
        mid();
        chk("rst_err", 32'(bus.err), 32'd0);
        tick();
    endtask

    // Monitor: every issued write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got sel %0d data %0h expected none", bus.writeregsel, bus.writedata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_sel", 32'(bus.writeregsel), 32'(w.sel));
                chk("wr_data", 32'(bus.writedata), 32'(w.data));
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.a_valid  = 1'b0;
        bus.a_regsel = '0;
        bus.a_data   = '0;
        bus.b_valid  = 1'b0;
        bus.b_regsel = '0;
        bus.b_data   = '0;
        bus.hold     = 1'b0;
        do_reset();

        // Single write
        bus.a_valid = 1'b1; bus.a_regsel = 3'd3; bus.a_data = 16'hBEEF;
        push(3'd3, 16'hBEEF);
        mid();
        chk("single_a_ready", 32'(bus.a_ready), 32'd1);
        chk("single_b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        bus.a_valid = 1'b0;
        mid();
        chk("single_write", 32'(bus.write), 32'd1);
        chk("single_pending", 32'(bus.pending), 32'h08);
        tick();

        // Contention after reset: A, B, A, B then A alone
        do_reset();
        bus.a_valid = 1'b1; bus.a_regsel = 3'd1; bus.a_data = 16'h1111;
        bus.b_valid = 1'b1; bus.b_regsel = 3'd2; bus.b_data = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(3'd1, 16'h1111);
            else            push(3'd2, 16'h2222);
            mid();
            chk("rr_a_ready", 32'(bus.a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", 32'(bus.b_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k > 0) chk("rr_write", 32'(bus.write), 32'd1);
            tick();
        end
        bus.b_valid = 1'b0;
        push(3'd1, 16'h1111);
        mid();
        chk("rr_a_alone", 32'(bus.a_ready), 32'd1);
        tick();
        bus.a_valid = 1'b0;
        mid();
        tick();

        // Hold: accept A r5, stall three cycles with B waiting
        bus.a_valid = 1'b1; bus.a_regsel = 3'd5; bus.a_data = 16'h0005;
        push(3'd5, 16'h0005);
        mid();
        chk("hold_a_ready", 32'(bus.a_ready), 32'd1);
        tick();
        bus.a_valid = 1'b0;
        bus.hold = 1'b1;
        bus.b_valid = 1'b1; bus.b_regsel = 3'd6; bus.b_data = 16'h0006;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("hold_write", 32'(bus.write), 32'd0);
            chk("hold_b_ready", 32'(bus.b_ready), 32'd0);
            chk("hold_pending", 32'(bus.pending), 32'h20);
            tick();
        end
        bus.hold = 1'b0;
        push(3'd6, 16'h0006);
        mid();
        chk("release_write", 32'(bus.write), 32'd1);
        chk("release_b_ready", 32'(bus.b_ready), 32'd1);
        tick();
        bus.b_valid = 1'b0;
        mid();
        chk("release_pending", 32'(bus.pending), 32'h40);
        chk("release_err", 32'(bus.err), 32'd0);
        tick();

        // Protocol error: B stalled then dropped
        bus.a_valid = 1'b1; bus.a_regsel = 3'd0; bus.a_data = 16'h00AA;
        push(3'd0, 16'h00AA);
        mid();
        tick();
        bus.a_valid = 1'b0;
        bus.hold = 1'b1;
        bus.b_valid = 1'b1; bus.b_regsel = 3'd1; bus.b_data = 16'h0B0B;
        mid();
        chk("perr_b_ready", 32'(bus.b_ready), 32'd0);
        chk("perr_err_pre", 32'(bus.err), 32'd0);
        tick();
        bus.b_valid = 1'b0;
        mid();
        chk("perr_err_drop", 32'(bus.err), 32'd0);
        tick();
        bus.hold = 1'b0;
        mid();
        chk("perr_err_set", 32'(bus.err), 32'd1);
        tick();
        mid();
        tick();
        mid();
        chk("perr_err_sticky", 32'(bus.err), 32'd1);
        tick();

        // Reset while a staged write is held: the write is discarded
        bus.a_valid = 1'b1; bus.a_regsel = 3'd7; bus.a_data = 16'h7777;
        mid();
        chk("rmid_a_ready", 32'(bus.a_ready), 32'd1);
        tick();
        bus.a_valid = 1'b0;
        bus.hold = 1'b1;
        mid();
        chk("rmid_pending", 32'(bus.pending), 32'h80);
        tick();
        rst = 1'b1;
        mid();
        chk("rmid_write_in_rst", 32'(bus.write), 32'd0);
        tick();
        rst = 1'b0;
        bus.hold = 1'b0;
        mid();
        chk("rmid_write", 32'(bus.write), 32'd0);
        chk("rmid_pending_clr", 32'(bus.pending), 32'h00);
        chk("rmid_err_clr", 32'(bus.err), 32'd0);
        tick();
        bus.a_valid = 1'b1; bus.a_regsel = 3'd3; bus.a_data = 16'h0303;
        bus.b_valid = 1'b1; bus.b_regsel = 3'd4; bus.b_data = 16'h0404;
        push(3'd3, 16'h0303);
        mid();
        chk("rmid_first_a", 32'(bus.a_ready), 32'd1);
        chk("rmid_first_b", 32'(bus.b_ready), 32'd0);
        tick();
        bus.a_valid = 1'b0;
        push(3'd4, 16'h0404);
        mid();
        chk("rmid_then_b", 32'(bus.b_ready), 32'd1);
        tick();
        bus.b_valid = 1'b0;
        mid();
        tick();

        // Back-to-back throughput
        for (int i = 0; i < 8; i++) begin
            bus.a_valid  = 1'b1;
            bus.a_regsel = 3'(i);
            bus.a_data   = 16'(i * 16'h0101);
            push(3'(i), 16'(i * 16'h0101));
            mid();
            chk("b2b_a_ready", 32'(bus.a_ready), 32'd1);
            if (i > 0) chk("b2b_write", 32'(bus.write), 32'd1);
            tick();
        end
        bus.a_valid = 1'b0;
        mid();
        chk("b2b_last_write", 32'(bus.write), 32'd1);
        chk("b2b_last_pending", 32'(bus.pending), 32'h80);
        tick();
        mid();
        chk("b2b_idle_write", 32'(bus.write), 32'd0);
        tick();
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
